// File: rtl/tbu_pkg.sv
// Shared types and helpers for the Viterbi traceback-unit controller.
package tbu_pkg;

  // Trellis states; also the width of one ACS decision word.
  localparam int NUM_STATES = 8;

  // Index of one of the three rotating survivor banks (values 0..2).
  typedef logic [1:0] bank_idx_t;

  // Job sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACE  = 2'd1,
    DECODE = 2'd2
  } tbu_ctrl_state_t;

  // Bank that follows b in the 0 -> 1 -> 2 -> 0 rotation.
  function automatic bank_idx_t next_bank(input bank_idx_t b);
    return (b == 2'd2) ? 2'd0 : b + 2'd1;
  endfunction

  // Bank that precedes b in the rotation.
  function automatic bank_idx_t prev_bank(input bank_idx_t b);
    return (b == 2'd0) ? 2'd2 : b - 2'd1;
  endfunction

endpackage

// File: rtl/tbu_ctrl_if.sv
// Decision-word input and tbu-facing output bundle of the traceback controller.
interface tbu_ctrl_if;
  import tbu_pkg::*;

  logic                  acs_valid;
  logic [NUM_STATES-1:0] acs_dec;
  logic                  tbu_enable;
  logic                  tbu_selection;
  logic [NUM_STATES-1:0] tbu_d_in_0;
  logic [NUM_STATES-1:0] tbu_d_in_1;
  logic                  busy;
  logic                  block_done;
  logic                  overflow;

  // Producer side: drives decision words, observes the tbu stream.
  modport master (
    output acs_valid, acs_dec,
    input  tbu_enable, tbu_selection, tbu_d_in_0, tbu_d_in_1,
    input  busy, block_done, overflow
  );

  // Controller side.
  modport slave (
    input  acs_valid, acs_dec,
    output tbu_enable, tbu_selection, tbu_d_in_0, tbu_d_in_1,
    output busy, block_done, overflow
  );

endinterface

// File: rtl/tb_bank_mem.sv
// One survivor bank: DEPTH decision words, one write port, one registered read port.
// Contents are deliberately not reset so the array maps onto block RAM.
module tb_bank_mem
  import tbu_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [NUM_STATES-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [NUM_STATES-1:0] o_rdata
);

  logic [NUM_STATES-1:0] r_mem [DEPTH];
  logic [NUM_STATES-1:0] r_rdata;

  // Synchronous write plus registered read (read-before-write on same address).
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/tbu_ctrl.sv
// Survivor-memory controller for the 8-state traceback unit.
// Decision words fill three rotating banks; every completed block (once two
// are available) launches a job that replays the newest bank backwards as
// training data (selection=0) and then the previous bank backwards as decode
// data (selection=1). Output data and phase tags leave two edges after the
// job is accepted: one edge for the bank read, one for the output register.
module tbu_ctrl
  import tbu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  tbu_ctrl_if.slave bus
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  // Write side
  bank_idx_t        r_wr_bank;
  logic [AW-1:0]    r_wr_addr;
  logic [1:0]       r_full_cnt;

  // Sequencer
  tbu_ctrl_state_t  r_state;
  logic [AW-1:0]    r_cnt;
  bank_idx_t        r_trace_bank;
  bank_idx_t        r_dec_bank;
  logic             r_pend;
  bank_idx_t        r_pend_trace;
  bank_idx_t        r_pend_dec;
  logic             r_overflow;

  // Read pipeline stage 1 (aligned with the registered bank read)
  logic             r_s1_en;
  logic             r_s1_sel;
  logic             r_s1_last;
  bank_idx_t        r_s1_bank;

  // Registered outputs
  logic                  r_enable;
  logic                  r_selection;
  logic [NUM_STATES-1:0] r_d_in_0;
  logic [NUM_STATES-1:0] r_d_in_1;
  logic                  r_block_done;

  logic                  w_wr_last;
  logic                  w_launch_req;
  logic                  w_last_read;
  logic                  w_accept;
  logic                  w_drop;
  logic [AW-1:0]         w_rd_addr;
  logic [2:0]            w_we;
  logic [NUM_STATES-1:0] w_rd_data [3];
  logic [NUM_STATES-1:0] w_rd_sel;

  assign w_wr_last    = bus.acs_valid && (r_wr_addr == LAST);
  // A completing write only launches once the bank before it is also full.
  assign w_launch_req = w_wr_last && (r_full_cnt != 2'd0);
  assign w_last_read  = (r_state == DECODE) && (r_cnt == LAST);
  // At exactly 50% input duty the next request lands on the final decode
  // read; it is parked for one cycle so tbu_enable still drops between jobs.
  assign w_accept     = ((r_state == IDLE) && !r_pend) || w_last_read;
  assign w_drop       = w_launch_req && !w_accept;
  // Traceback walks each bank from the newest word down to address 0.
  assign w_rd_addr    = LAST - r_cnt;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_bank
      assign w_we[gi] = bus.acs_valid && (r_wr_bank == bank_idx_t'(gi));

      tb_bank_mem #(
        .DEPTH (DEPTH)
      ) u_bank (
        .clk     (clk),
        .i_we    (w_we[gi]),
        .i_waddr (r_wr_addr),
        .i_wdata (bus.acs_dec),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data[gi])
      );
    end
  endgenerate

  // Write pointer, bank rotation and count of completed banks (saturating at 2).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank  <= 2'd0;
      r_wr_addr  <= '0;
      r_full_cnt <= 2'd0;
    end else if (bus.acs_valid) begin
      if (w_wr_last) begin
        r_wr_addr <= '0;
        r_wr_bank <= next_bank(r_wr_bank);
        if (r_full_cnt != 2'd2) begin
          r_full_cnt <= r_full_cnt + 2'd1;
        end
      end else begin
        r_wr_addr <= r_wr_addr + AW'(1);
      end
    end
  end

  // Job sequencer: IDLE -> TRACE (DEPTH reads) -> DECODE (DEPTH reads) -> IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_trace_bank <= 2'd0;
      r_dec_bank   <= 2'd0;
      r_pend       <= 1'b0;
      r_pend_trace <= 2'd0;
      r_pend_dec   <= 2'd0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (r_pend) begin
            r_state      <= TRACE;
            r_trace_bank <= r_pend_trace;
            r_dec_bank   <= r_pend_dec;
            r_pend       <= 1'b0;
          end else if (w_launch_req) begin
            r_state      <= TRACE;
            r_trace_bank <= r_wr_bank;
            r_dec_bank   <= prev_bank(r_wr_bank);
          end
        end
        TRACE: begin
          if (r_cnt == LAST) begin
            r_state <= DECODE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        DECODE: begin
          if (r_cnt == LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            if (w_launch_req) begin
              r_pend       <= 1'b1;
              r_pend_trace <= r_wr_bank;
              r_pend_dec   <= prev_bank(r_wr_bank);
            end
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Pick the word of the bank being replayed from the registered reads.
  always_comb begin
    w_rd_sel = '0;
    case (r_s1_bank)
      2'd0:    w_rd_sel = w_rd_data[0];
      2'd1:    w_rd_sel = w_rd_data[1];
      2'd2:    w_rd_sel = w_rd_data[2];
      default: w_rd_sel = '0;
    endcase
  end

  // Delay phase tags one cycle to meet the read data, then register the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_en      <= 1'b0;
      r_s1_sel     <= 1'b0;
      r_s1_last    <= 1'b0;
      r_s1_bank    <= 2'd0;
      r_enable     <= 1'b0;
      r_selection  <= 1'b0;
      r_d_in_0     <= '0;
      r_d_in_1     <= '0;
      r_block_done <= 1'b0;
    end else begin
      r_s1_en      <= (r_state != IDLE);
      r_s1_sel     <= (r_state == DECODE);
      r_s1_last    <= w_last_read;
      r_s1_bank    <= (r_state == DECODE) ? r_dec_bank : r_trace_bank;
      r_enable     <= r_s1_en;
      r_selection  <= r_s1_en && r_s1_sel;
      r_d_in_0     <= (r_s1_en && !r_s1_sel) ? w_rd_sel : '0;
      r_d_in_1     <= (r_s1_en &&  r_s1_sel) ? w_rd_sel : '0;
      r_block_done <= r_s1_last;
    end
  end

  assign bus.tbu_enable    = r_enable;
  assign bus.tbu_selection = r_selection;
  assign bus.tbu_d_in_0    = r_d_in_0;
  assign bus.tbu_d_in_1    = r_d_in_1;
  assign bus.block_done    = r_block_done;
  assign bus.overflow      = r_overflow;
  assign bus.busy          = (r_state != IDLE);

endmodule

// File: tb/tb_tbu_ctrl.sv
// Self-checking bench for tbu_ctrl (DEPTH=4) against a bank/queue model.
module tb_tbu_ctrl;

  localparam int D = 4;

  typedef struct {
    bit         sel;
    logic [7:0] d0;
    logic [7:0] d1;
    bit         done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tbu_ctrl_if u_if ();

  tbu_ctrl #(.DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_done = 0;

  // Reference model state
  logic [7:0] m_bank [3][D];
  int   m_wb, m_wa, m_full, m_next_free;
  bit   ov_exp;
  bit   data_ok = 1'b1;
  exp_t exp_q[$];
  int   rise_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_wb = 0; m_wa = 0; m_full = 0; m_next_free = -1000;
    ov_exp = 1'b0;
    exp_q.delete();
    rise_q.delete();
  endtask

  // Store a word written at edge r; on a completed block possibly queue a job.
  task automatic model_write(input logic [7:0] d, input int r);
    int tb_i, db_i, s;
    bit req;
    exp_t e;
    m_bank[m_wb][m_wa] = d;
    if (m_wa == D - 1) begin
      tb_i = m_wb;
      db_i = (m_wb + 2) % 3;
      req  = (m_full >= 1);
      if (m_full < 2) m_full++;
      m_wb = (m_wb + 1) % 3;
      m_wa = 0;
      if (req) begin
        if (r < m_next_free) begin
          ov_exp = 1'b1;
        end else begin
          s = (r == m_next_free) ? r + 1 : r;
          rise_q.push_back(s + 2);
          for (int i = D - 1; i >= 0; i--) begin
            e.sel = 1'b0; e.d0 = m_bank[tb_i][i]; e.d1 = 8'h00; e.done = 1'b0;
            exp_q.push_back(e);
          end
          for (int i = D - 1; i >= 0; i--) begin
            e.sel = 1'b1; e.d0 = 8'h00; e.d1 = m_bank[db_i][i]; e.done = (i == 0);
            exp_q.push_back(e);
          end
          m_next_free = s + 2 * D;
        end
      end
    end else begin
      m_wa++;
    end
  endtask

  // Output monitor: stream order, latency, idle quietness, gap between jobs.
  bit prev_en = 1'b0;
  bit prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    check("overflow", u_if.overflow, ov_exp);
    if (u_if.tbu_enable === 1'b1) begin
      check("gap_between_jobs", prev_done, 0);
      if (!prev_en) begin
        check("job_expected", rise_q.size() > 0, 1);
        if (rise_q.size() > 0) check("enable_rise_cycle", cyc, rise_q.pop_front());
      end
      check("word_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("selection", u_if.tbu_selection, e.sel);
        check("block_done", u_if.block_done, e.done);
        if (data_ok) begin
          check("d_in_0", u_if.tbu_d_in_0, e.d0);
          check("d_in_1", u_if.tbu_d_in_1, e.d1);
        end else if (e.sel) begin
          check("d_in_0_quiet", u_if.tbu_d_in_0, 0);
        end else begin
          check("d_in_1_quiet", u_if.tbu_d_in_1, 0);
        end
      end
    end else begin
      check("idle_outputs", {u_if.tbu_enable, u_if.tbu_selection, u_if.tbu_d_in_0,
                             u_if.tbu_d_in_1, u_if.block_done}, 0);
    end
    if (u_if.block_done === 1'b1) n_done++;
    prev_en   = (u_if.tbu_enable === 1'b1);
    prev_done = (u_if.block_done === 1'b1);
  end

  task automatic write_word(input logic [7:0] d, input int gap);
    u_if.acs_valid = 1'b1;
    u_if.acs_dec   = d;
    @(posedge clk); #1;
    model_write(d, cyc);
    u_if.acs_valid = 1'b0;
    u_if.acs_dec   = 8'h00;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() > 0 || rise_q.size() > 0 || u_if.busy === 1'b1) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (3) begin @(posedge clk); #1; end
    check("drain_words_left", exp_q.size(), 0);
    check("drain_jobs_left", rise_q.size(), 0);
    check("drain_busy", u_if.busy, 0);
  endtask

  initial begin
    int d0;
    logic [7:0] w;
    u_if.acs_valid = 1'b0;
    u_if.acs_dec   = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_enable", u_if.tbu_enable, 0);
    check("rst_selection", u_if.tbu_selection, 0);
    check("rst_data", {u_if.tbu_d_in_0, u_if.tbu_d_in_1}, 0);
    check("rst_busy", u_if.busy, 0);
    check("rst_done_ovf", {u_if.block_done, u_if.overflow}, 0);

    // 1: bank0=01..04, bank1=11..14 at 50% duty -> one job
    d0 = n_done;
    for (int i = 0; i < 4; i++) write_word(8'(8'h01 + i), 1);
    for (int i = 0; i < 4; i++) write_word(8'(8'h11 + i), 1);
    drain();
    check("s1_jobs", n_done - d0, 1);

    // 2: twelve random words at 50% duty -> two jobs, no overflow
    do_reset();
    d0 = n_done;
    for (int i = 0; i < 12; i++) write_word(8'($urandom), 1);
    drain();
    check("s2_jobs", n_done - d0, 2);
    check("s2_overflow", u_if.overflow, 0);

    // 3: sixteen words at 100% duty -> overflow on 12th write, 16th launches
    do_reset();
    data_ok = 1'b0;
    d0 = n_done;
    for (int i = 0; i < 16; i++) begin
      write_word(8'($urandom), 0);
      if (i == 10) check("s3_no_ovf_before_12", u_if.overflow, 0);
      if (i == 11) check("s3_ovf_at_12", u_if.overflow, 1);
    end
    drain();
    check("s3_jobs", n_done - d0, 2);
    check("s3_ovf_sticky", u_if.overflow, 1);
    data_ok = 1'b1;

    // 4: reset during the decode phase
    do_reset();
    for (int i = 0; i < 4; i++) write_word(8'(8'h01 + i), 1);
    for (int i = 0; i < 4; i++) write_word(8'(8'h11 + i), (i == 3) ? 0 : 1);
    repeat (6) begin @(posedge clk); #1; end
    check("s4_busy_before_rst", u_if.busy, 1);
    check("s4_decoding_before_rst", u_if.tbu_selection, 1);
    do_reset();
    check("s4_enable_after_rst", u_if.tbu_enable, 0);
    check("s4_sel_after_rst", u_if.tbu_selection, 0);
    check("s4_busy_after_rst", u_if.busy, 0);
    check("s4_ovf_after_rst", u_if.overflow, 0);
    d0 = n_done;
    for (int i = 0; i < 4; i++) write_word(8'($urandom), 1);
    repeat (10) begin @(posedge clk); #1; end
    check("s4_no_job_after_4", n_done - d0, 0);
    for (int i = 0; i < 4; i++) write_word(8'($urandom), 1);
    drain();
    check("s4_one_job_after_8", n_done - d0, 1);

    // 5: irregular gaps, same data as scenario 1
    do_reset();
    d0 = n_done;
    for (int i = 0; i < 8; i++) begin
      w = (i < 4) ? 8'(8'h01 + i) : 8'(8'h11 + i - 4);
      write_word(w, int'($urandom_range(0, 5)));
    end
    drain();
    check("s5_jobs", n_done - d0, 1);

    // Random words at <= 50% duty -> a job per block from the second on
    do_reset();
    d0 = n_done;
    for (int i = 0; i < 24; i++) write_word(8'($urandom), int'($urandom_range(1, 3)));
    drain();
    check("rand_jobs", n_done - d0, 5);
    check("rand_overflow", u_if.overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
